// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store unit driving a word-organised data memory with sub-word read-modify-write
//   CLK, RST                      clock, synchronous active-high reset
//   REQ_VALID/READY/WE/FUNCT3     core request handshake and access kind
//   REQ_ADDR, REQ_WDATA           byte address and store data
//   RSP_VALID/READY/RDATA/ERR     response handshake, extended load data, error flag
//   MEM_WE, MEM_A, MEM_WD, MEM_RD word memory interface (combinational read)
module lsu_mem_master #(
    parameter int MEM_WORDS = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [2:0]  REQ_FUNCT3,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        MEM_WE,
    output logic [31:0] MEM_A,
    output logic [31:0] MEM_WD,
    input  logic [31:0] MEM_RD
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;
    state_t state;
    logic [2:0]  funct3;
    logic [31:0] addr, merge, rdata, load_val, merged;
    logic [15:0] wdata;
    logic        err, req_err;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    assign req_err = !(REQ_FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                   || (REQ_WE && REQ_FUNCT3[2])
                   || (REQ_FUNCT3[1:0] == 2'b01 && REQ_ADDR[0])
                   || (REQ_FUNCT3[1:0] == 2'b10 && REQ_ADDR[1:0] != 2'b00)
                   || (REQ_ADDR >= 32'(MEM_WORDS * 4));
    assign byte_lane = MEM_RD[{addr[1:0], 3'b000} +: 8];
    assign half_lane = MEM_RD[{addr[1], 4'b0000} +: 16];
    always_comb begin
        load_val = funct3 == 3'b000 ? {{24{byte_lane[7]}}, byte_lane} :
                   funct3 == 3'b100 ? {24'b0, byte_lane} :
                   funct3 == 3'b001 ? {{16{half_lane[15]}}, half_lane} :
                   funct3 == 3'b101 ? {16'b0, half_lane} : MEM_RD;
    end
    // Only the addressed lane changes; the rest of the word is written back as read.
    always_comb begin
        merged = MEM_RD;
        if (funct3[0])
            merged[{addr[1], 4'b0000} +: 16] = wdata;
        else
            merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            funct3 <= '0;
            addr   <= '0;
            wdata  <= '0;
            merge  <= '0;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (REQ_VALID) begin
                    funct3 <= REQ_FUNCT3;
                    addr   <= REQ_ADDR;
                    wdata  <= REQ_WDATA[15:0];
                    merge  <= REQ_WDATA;
                    rdata  <= '0;
                    err    <= req_err;
                    state  <= req_err ? RESP : !REQ_WE ? LOAD : REQ_FUNCT3[1] ? WRITE : RMW_READ;
                end
                LOAD: begin
                    rdata <= load_val;
                    state <= RESP;
                end
                RMW_READ: begin
                    merge <= merged;
                    state <= WRITE;
                end
                WRITE: state <= RESP;
                RESP: if (RSP_READY) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign REQ_READY = state == IDLE;
    assign RSP_VALID = state == RESP;
    assign RSP_RDATA = rdata;
    assign RSP_ERR   = err;
    // Gated by RST so a reset landing on the WRITE cycle never commits the word.
    assign MEM_WE    = state == WRITE && !RST;
    assign MEM_A     = {addr[31:2], 2'b00};
    assign MEM_WD    = state == WRITE ? merge : '0;
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: scoreboard bench for lsu_mem_master against a behavioural word memory
module tb_lsu_mem_master;
    logic        CLK = 0, RST = 1;
    logic        REQ_VALID = 0, REQ_WE = 0, RSP_READY = 1;
    logic [2:0]  REQ_FUNCT3 = 0;
    logic [31:0] REQ_ADDR = 0, REQ_WDATA = 0;
    logic        REQ_READY, RSP_VALID, RSP_ERR, MEM_WE;
    logic [31:0] RSP_RDATA, MEM_A, MEM_WD, MEM_RD;
    logic [31:0] mem [0:63];
    int cyc = 0, checks = 0, errors = 0;

    typedef struct {logic [31:0] rdata; logic err; int lat; int acc;} rsp_t;
    typedef struct {logic [31:0] a; logic [31:0] d; int lat; int acc;} wr_t;
    rsp_t rq[$];
    wr_t  wq[$];
    rsp_t r;
    wr_t  w;
    logic        seen = 0;
    logic [31:0] first_rdata;
    logic        first_err;

    lsu_mem_master #(.MEM_WORDS(64)) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_WE(REQ_WE), .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .MEM_WE(MEM_WE), .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    assign MEM_RD = mem[MEM_A[7:2]];
    always @(posedge CLK) if (MEM_WE) mem[MEM_A[7:2]] <= MEM_WD;

    always @(negedge CLK) begin
        if (MEM_WE) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write MEM_A=%h MEM_WD=%h", MEM_A, MEM_WD);
            end else begin
                w = wq.pop_front();
                if (MEM_A !== w.a || MEM_WD !== w.d || cyc - w.acc + 1 != w.lat) begin
                    errors++;
                    $display("FAIL write got a=%h d=%h lat=%0d want a=%h d=%h lat=%0d",
                             MEM_A, MEM_WD, cyc - w.acc + 1, w.a, w.d, w.lat);
                end
            end
        end
        if (RSP_VALID) begin
            checks++;
            if (!seen) begin
                seen = 1;
                first_rdata = RSP_RDATA;
                first_err = RSP_ERR;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp rdata=%h err=%b", RSP_RDATA, RSP_ERR);
                end else if (cyc - rq[0].acc + 1 != rq[0].lat) begin
                    errors++;
                    $display("FAIL rsp_latency got %0d want %0d", cyc - rq[0].acc + 1, rq[0].lat);
                end
            end else if (RSP_RDATA !== first_rdata || RSP_ERR !== first_err || REQ_READY !== 1'b0) begin
                errors++;
                $display("FAIL rsp_stable got rdata=%h err=%b ready=%b want rdata=%h err=%b ready=0",
                         RSP_RDATA, RSP_ERR, REQ_READY, first_rdata, first_err);
            end
            if (RSP_READY) begin
                seen = 0;
                if (rq.size() > 0) begin
                    r = rq.pop_front();
                    checks++;
                    if (RSP_RDATA !== r.rdata || RSP_ERR !== r.err) begin
                        errors++;
                        $display("FAIL rsp got rdata=%h err=%b want rdata=%h err=%b",
                                 RSP_RDATA, RSP_ERR, r.rdata, r.err);
                    end
                end
            end
        end
    end

    task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int el,
                       input logic hw, input logic [31:0] wa, input logic [31:0] wdv, input int wl,
                       input logic wait_rsp);
        int n = 0;
        @(negedge CLK);
        while (!REQ_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!REQ_READY) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout addr=%h", a);
        end
        REQ_VALID = 1;
        REQ_WE = we;
        REQ_FUNCT3 = f3;
        REQ_ADDR = a;
        REQ_WDATA = wd;
        @(posedge CLK);
        #1;
        REQ_VALID = 0;
        rq.push_back('{er, ee, el, cyc});
        if (hw) wq.push_back('{wa, wdv, wl, cyc});
        if (wait_rsp) begin
            n = 0;
            while ((rq.size() != 0 || wq.size() != 0) && n < 20) begin
                @(negedge CLK);
                n++;
            end
            if (rq.size() != 0 || wq.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_timeout addr=%h pending rsp=%0d wr=%0d", a, rq.size(), wq.size());
                rq.delete();
                wq.delete();
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'h8899AABB;
        mem[63] = 32'h7F000001;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({REQ_READY, RSP_VALID, RSP_ERR, MEM_WE} !== 4'b1000 || RSP_RDATA !== 0 || MEM_A !== 0 || MEM_WD !== 0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b err=%b we=%b rd=%h a=%h wd=%h want 1 0 0 0 0 0 0",
                     REQ_READY, RSP_VALID, RSP_ERR, MEM_WE, RSP_RDATA, MEM_A, MEM_WD);
        end
        RST = 0;
        req(0, 3'b000, 32'h11, 0, 32'hFFFFFFAA, 0, 2, 0, 0, 0, 0, 1);
        req(0, 3'b100, 32'h11, 0, 32'h000000AA, 0, 2, 0, 0, 0, 0, 1);
        req(0, 3'b001, 32'h12, 0, 32'hFFFF8899, 0, 2, 0, 0, 0, 0, 1);
        req(1, 3'b000, 32'h12, 32'h123456CC, 0, 0, 3, 1, 32'h10, 32'h88CCAABB, 2, 1);
        req(0, 3'b010, 32'h10, 0, 32'h88CCAABB, 0, 2, 0, 0, 0, 0, 1);
        req(1, 3'b010, 32'h20, 32'hDEADBEEF, 0, 0, 2, 1, 32'h20, 32'hDEADBEEF, 1, 1);
        req(0, 3'b010, 32'h20, 0, 32'hDEADBEEF, 0, 2, 0, 0, 0, 0, 1);
        req(0, 3'b101, 32'h22, 0, 32'h0000DEAD, 0, 2, 0, 0, 0, 0, 1);
        req(1, 3'b001, 32'h22, 32'hFFFF1234, 0, 0, 3, 1, 32'h20, 32'h1234BEEF, 2, 1);
        req(0, 3'b000, 32'h20, 0, 32'hFFFFFFEF, 0, 2, 0, 0, 0, 0, 1);
        req(0, 3'b010, 32'hFC, 0, 32'h7F000001, 0, 2, 0, 0, 0, 0, 1);
        req(0, 3'b100, 32'hFF, 0, 32'h0000007F, 0, 2, 0, 0, 0, 0, 1);
        req(0, 3'b001, 32'h13, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        req(0, 3'b010, 32'h100, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        req(0, 3'b011, 32'h10, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        req(1, 3'b100, 32'h10, 32'h55, 0, 1, 1, 0, 0, 0, 0, 1);
        req(1, 3'b010, 32'h22, 32'h55, 0, 1, 1, 0, 0, 0, 0, 1);
        req(1, 3'b000, 32'h100, 32'h55, 0, 1, 1, 0, 0, 0, 0, 1);
        RSP_READY = 0;
        req(0, 3'b010, 32'h10, 0, 32'h88CCAABB, 0, 2, 0, 0, 0, 0, 0);
        repeat (5) @(posedge CLK);
        #1;
        checks++;
        if (RSP_VALID !== 1'b1 || REQ_READY !== 1'b0) begin
            errors++;
            $display("FAIL hold_rsp got vld=%b rdy=%b want vld=1 rdy=0", RSP_VALID, REQ_READY);
        end
        RSP_READY = 1;
        @(posedge CLK);
        #1;
        checks++;
        if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0 || rq.size() != 0) begin
            errors++;
            $display("FAIL release_rsp got rdy=%b vld=%b pending=%0d want rdy=1 vld=0 pending=0",
                     REQ_READY, RSP_VALID, rq.size());
        end
        @(negedge CLK);
        REQ_VALID = 1;
        REQ_WE = 1;
        REQ_FUNCT3 = 3'b000;
        REQ_ADDR = 32'h10;
        REQ_WDATA = 32'h55;
        @(posedge CLK);
        #1;
        REQ_VALID = 0;
        @(posedge CLK);
        #1;
        RST = 1;
        #1;
        checks++;
        if (MEM_WE !== 1'b0) begin
            errors++;
            $display("FAIL reset_write_gate got MEM_WE=%b want 0", MEM_WE);
        end
        @(posedge CLK);
        #1;
        RST = 0;
        checks++;
        if ({REQ_READY, RSP_VALID, RSP_ERR, MEM_WE} !== 4'b1000 || RSP_RDATA !== 0 || MEM_A !== 0 || MEM_WD !== 0
            || mem[4] !== 32'h88CCAABB) begin
            errors++;
            $display("FAIL midop_reset got rdy=%b vld=%b err=%b we=%b rd=%h a=%h wd=%h mem=%h want 1 0 0 0 0 0 0 88ccaabb",
                     REQ_READY, RSP_VALID, RSP_ERR, MEM_WE, RSP_RDATA, MEM_A, MEM_WD, mem[4]);
        end
        req(0, 3'b010, 32'h10, 0, 32'h88CCAABB, 0, 2, 0, 0, 0, 0, 1);
        repeat (3) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
